l1_dcache_nway: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate L1 data cache with one 32-bit word per line. It sits between the core load/store unit and the backing RAM. It generalises the fixed 2-way cache in three ways:
- configurable ways and sets;
- byte-strobed writes;
- a flush mode that writes back every dirty line.

---
 rtl/l1_dcache_nway.sv | 269 ++++++++++++++++++++++++++
 tb/tb_l1_dcache_nway.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_dcache_nway.sv
// l1_dcache_nway: N-way set-associative, write-back, write-allocate L1 data
// cache with one 32-bit word per line, byte-strobed stores, true-LRU
// replacement via per-way age counters and a flush walk that writes back every
// dirty line. The reset input is active-low.
module l1_dcache_nway #(
  parameter int WAYS   = 2,
  parameter int SETS   = 512,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              flush_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int WORD_W = ADDR_W - 2;
  localparam int TAG_W  = WORD_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_REFILL    = 3'd3;
  localparam logic [2:0] S_RESPOND   = 3'd4;
  localparam logic [2:0] S_FLUSH     = 3'd5;

  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   dirty_q [WAYS];
  logic [WAY_W-1:0]  age_q   [WAYS][SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [DATA_W-1:0] data_q  [WAYS][SETS];

  logic [2:0]        state_q;
  logic              write_q;
  logic [WORD_W-1:0] word_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [WAY_W-1:0]  victim_q;
  logic [IDX_W-1:0]  flush_set_q;
  logic [WAY_W-1:0]  flush_way_q;
  logic              flush_done_q;
  logic [DATA_W-1:0] resp_rdata_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  lru_way;
  logic [WAY_W-1:0]  victim;
  logic [DATA_W-1:0] hit_line;
  logic [DATA_W-1:0] fill_line;
  logic              lookup_hit;
  logic              refill_done;
  logic              flush_ack;
  logic              touch_en;
  logic [WAY_W-1:0]  touch_way;
  logic              flush_entry_dirty;
  logic              flush_last_way;
  logic              flush_last_set;
  logic              addr_unused;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_data,
                                                    input logic [DATA_W-1:0] new_data,
                                                    input logic [3:0]        strb);
    logic [DATA_W-1:0] res;
    res = old_data;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_data[8*b +: 8];
    end
    return res;
  endfunction

  assign idx         = word_q[IDX_W-1:0];
  assign tag         = word_q[WORD_W-1:IDX_W];
  assign addr_unused = ^req_addr[1:0];

  // Parallel tag compare plus victim selection (lowest invalid way, else oldest).
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[w][idx]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_q[w][idx] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
  end

  assign victim      = inv_found ? inv_way : lru_way;
  assign hit_line    = write_q ? merge_bytes(data_q[hit_way][idx], wdata_q, wstrb_q)
                               : data_q[hit_way][idx];
  assign fill_line   = write_q ? merge_bytes(mem_rdata, wdata_q, wstrb_q) : mem_rdata;
  assign lookup_hit  = (state_q == S_LOOKUP) && hit;
  assign refill_done = (state_q == S_REFILL) && mem_req && mem_ack;
  assign flush_ack   = (state_q == S_FLUSH) && mem_req && mem_ack;
  assign touch_en    = lookup_hit || refill_done;
  assign touch_way   = lookup_hit ? hit_way : victim_q;

  assign flush_entry_dirty = valid_q[flush_way_q][flush_set_q] && dirty_q[flush_way_q][flush_set_q];
  assign flush_last_way    = (flush_way_q == WAY_W'(WAYS - 1));
  assign flush_last_set    = (flush_set_q == IDX_W'(SETS - 1));

  assign req_ready  = reset && (state_q == S_IDLE) && !flush_req;
  assign resp_valid = (state_q == S_RESPOND);
  assign resp_rdata = resp_rdata_q;
  assign flush_busy = (state_q == S_FLUSH);
  assign flush_done = flush_done_q;

  // Valid/dirty/age bookkeeping; the only per-line state cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
        for (int s = 0; s < SETS; s++) age_q[w][s] <= WAY_W'(w);
      end
    end else begin
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[w][idx] < age_q[touch_way][idx]) age_q[w][idx] <= age_q[w][idx] + 1'b1;
        end
        age_q[touch_way][idx] <= '0;
      end
      if (refill_done) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= write_q;
      end
      if (lookup_hit && write_q) dirty_q[hit_way][idx] <= 1'b1;
      if (flush_ack) dirty_q[flush_way_q][flush_set_q] <= 1'b0;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard their contents.
  always_ff @(posedge clk) begin
    if (refill_done) begin
      tag_q[victim_q][idx]  <= tag;
      data_q[victim_q][idx] <= fill_line;
    end
    if (lookup_hit && write_q) data_q[hit_way][idx] <= hit_line;
  end

  // Main controller: request latch, miss handling, RAM handshake and flush walk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      word_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      victim_q     <= '0;
      flush_set_q  <= '0;
      flush_way_q  <= '0;
      flush_done_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (flush_req) begin
            state_q     <= S_FLUSH;
            flush_set_q <= '0;
            flush_way_q <= '0;
          end else if (req_valid) begin
            write_q <= req_write;
            word_q  <= req_addr[ADDR_W-1:2];
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            resp_rdata_q <= hit_line;
            state_q      <= S_RESPOND;
          end else begin
            victim_q <= victim;
            mem_req  <= 1'b1;
            if (valid_q[victim][idx] && dirty_q[victim][idx]) begin
              mem_we    <= 1'b1;
              mem_addr  <= {tag_q[victim][idx], idx};
              mem_wdata <= data_q[victim][idx];
              state_q   <= S_WRITEBACK;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= word_q;
              state_q  <= S_REFILL;
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state_q <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= word_q;
          end else if (mem_ack) begin
            mem_req      <= 1'b0;
            resp_rdata_q <= fill_line;
            state_q      <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          state_q <= S_IDLE;
        end
        S_FLUSH: begin
          if (mem_req) begin
            if (mem_ack) mem_req <= 1'b0;
          end else if (flush_entry_dirty) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {tag_q[flush_way_q][flush_set_q], flush_set_q};
            mem_wdata <= data_q[flush_way_q][flush_set_q];
          end
          if (flush_ack || (!mem_req && !flush_entry_dirty)) begin
            if (flush_last_way) begin
              flush_way_q <= '0;
              if (flush_last_set) begin
                state_q      <= S_IDLE;
                flush_done_q <= 1'b1;
              end else begin
                flush_set_q <= flush_set_q + 1'b1;
              end
            end else begin
              flush_way_q <= flush_way_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_dcache_nway.sv
// tb_l1_dcache_nway: directed bench for l1_dcache_nway with a recency-list
// cache model, a RAM responder and a per-cycle compare process.
module tb_l1_dcache_nway;

  localparam int WAYS  = 2;
  localparam int SETS  = 512;
  localparam int IDX_W = 9;
  localparam int TAG_W = 21;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        flush_req = 1'b0;
  logic        flush_busy;
  logic        flush_done;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  l1_dcache_nway #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             dirty;
    logic [3:0]       way;
  } line_t;

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
  } txn_t;

  line_t       setQ [SETS][$];
  txn_t        expMem[$];
  txn_t        seenMem[$];
  logic [31:0] expResp[$];
  logic [31:0] ramMem [int];
  logic [31:0] lastResp = '0;
  int          expDone = 0;
  int          seenDone = 0;
  int          memLatency = 1;
  int          checks = 0;
  int          errors = 0;
  txn_t        cmpT;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ramRead(input logic [29:0] a);
    if (ramMem.exists(int'(a))) return ramMem[int'(a)];
    return 32'h5A5A0000 ^ {2'b00, a};
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Model: each set is a list ordered most-recent first; a full set evicts its tail.
  function automatic void modelAccess(input bit wr, input logic [31:0] addr,
                                      input logic [31:0] wd, input logic [3:0] strb);
    logic [29:0]      word;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    line_t            l;
    int               pos;
    bit               used [WAYS];
    word = addr[31:2];
    idx  = word[IDX_W-1:0];
    tag  = word[29:IDX_W];
    pos  = -1;
    l    = '0;
    for (int i = 0; i < setQ[idx].size(); i++) if (setQ[idx][i].tag == tag) pos = i;
    if (pos >= 0) begin
      l = setQ[idx][pos];
      setQ[idx].delete(pos);
    end else begin
      if (setQ[idx].size() == WAYS) begin
        l = setQ[idx].pop_back();
        if (l.dirty) begin
          expMem.push_back('{we: 1'b1, addr: {l.tag, idx}, wdata: l.data});
          ramMem[int'({l.tag, idx})] = l.data;
        end
      end else begin
        for (int w = 0; w < WAYS; w++) used[w] = 1'b0;
        for (int i = 0; i < setQ[idx].size(); i++) used[setQ[idx][i].way] = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) if (!used[w]) l.way = 4'(w);
      end
      expMem.push_back('{we: 1'b0, addr: word, wdata: 32'h0});
      l.tag   = tag;
      l.data  = ramRead(word);
      l.dirty = 1'b0;
    end
    if (wr) begin
      l.data  = mergeBytes(l.data, wd, strb);
      l.dirty = 1'b1;
    end
    setQ[idx].push_front(l);
    expResp.push_back(l.data);
  endfunction

  function automatic void modelFlush();
    line_t t;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        for (int i = 0; i < setQ[s].size(); i++) begin
          t = setQ[s][i];
          if (t.way == 4'(w) && t.dirty) begin
            expMem.push_back('{we: 1'b1, addr: {t.tag, IDX_W'(s)}, wdata: t.data});
            ramMem[int'({t.tag, IDX_W'(s)})] = t.data;
            t.dirty = 1'b0;
            setQ[s][i] = t;
          end
        end
    expDone++;
  endfunction

  function automatic void modelReset();
    for (int s = 0; s < SETS; s++) setQ[s].delete();
    expMem.delete();
    expResp.delete();
  endfunction

  // RAM responder: acks each request after memLatency extra cycles.
  initial begin
    int lat;
    lat = 0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack = 1'b0;
      if (reset && mem_req) begin
        if (lat >= memLatency) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_we ? 32'h0 : ramRead(mem_addr);
          lat       = 0;
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // Compare process: every completed RAM transaction, response and flush_done.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (mem_req && mem_ack) begin
          seenMem.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
          if (expMem.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_mem: actual we=%0b addr=%h required=none", mem_we, mem_addr);
          end else begin
            cmpT = expMem.pop_front();
            checkOutput("mem_we", {31'b0, mem_we}, {31'b0, cmpT.we});
            checkOutput("mem_addr", {2'b00, mem_addr}, {2'b00, cmpT.addr});
            if (cmpT.we) checkOutput("mem_wdata", mem_wdata, cmpT.wdata);
          end
        end
        if (resp_valid) begin
          lastResp = resp_rdata;
          if (expResp.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_resp: actual=%h required=none", resp_rdata);
          end else begin
            checkOutput("resp_rdata", resp_rdata, expResp.pop_front());
          end
        end
        if (flush_done) begin
          seenDone++;
          checks++;
          if (expDone == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_flush_done: actual=1 required=0");
          end else begin
            expDone--;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] strb, output int lat);
    int n;
    modelAccess(wr, addr, wd, strb);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = strb;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
    end
    checkOutput("resp_seen", {31'b0, resp_valid}, 32'd1);
    lat = n;
    #1;
    checkOutput("exp_mem_drained", expMem.size(), 32'd0);
    checkOutput("exp_resp_drained", expResp.size(), 32'd0);
  endtask

  task automatic doFlush();
    int n, d0;
    d0 = seenDone;
    modelFlush();
    @(negedge clk);
    flush_req = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0040;
    #1 checkOutput("flush_priority_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy_high", {31'b0, flush_busy}, 32'd1);
    n = 0;
    while (seenDone == d0 && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("flush_done_seen", seenDone, d0 + 1);
    @(negedge clk);
    #1;
    checkOutput("flush_busy_low", {31'b0, flush_busy}, 32'd0);
    checkOutput("flush_done_once", seenDone, d0 + 1);
    checkOutput("flush_exp_drained", expMem.size(), 32'd0);
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, m0, n;
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_flush_busy", {31'b0, flush_busy}, 32'd0);
    checkOutput("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
    reset = 1'b1;
    #1 checkOutput("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    // 1: cold miss then hit
    ramMem[32'h200] = 32'hAAAAAAAA;
    m0 = seenMem.size();
    applyStimulus(1'b0, 32'h0000_0802, 32'h0, 4'h0, lat);
    checkOutput("t1_refill_count", seenMem.size(), m0 + 1);
    checkOutput("t1_refill_addr", {2'b00, seenMem[seenMem.size()-1].addr}, 32'h200);
    checkOutput("t1_rdata", lastResp, 32'hAAAAAAAA);
    m0 = seenMem.size();
    applyStimulus(1'b0, 32'h0000_0802, 32'h0, 4'h0, lat);
    checkOutput("t1_hit_latency", lat, 32'd2);
    checkOutput("t1_hit_no_mem", seenMem.size(), m0);

    // 2: LRU replacement in set 0
    applyStimulus(1'b0, 32'hABCD_E802, 32'h0, 4'h0, lat);
    checkOutput("t2_refill_addr", {2'b00, seenMem[seenMem.size()-1].addr}, 32'h2AF37A00);
    applyStimulus(1'b0, 32'h0000_0802, 32'h0, 4'h0, lat);
    checkOutput("t2_rehit_latency", lat, 32'd2);
    m0 = seenMem.size();
    applyStimulus(1'b0, 32'hAAAA_A802, 32'h0, 4'h0, lat);
    checkOutput("t2_evict_count", seenMem.size(), m0 + 1);
    checkOutput("t2_evict_addr", {2'b00, seenMem[seenMem.size()-1].addr}, 32'h2AAAAA00);
    m0 = seenMem.size();
    applyStimulus(1'b0, 32'hABCD_E802, 32'h0, 4'h0, lat);
    checkOutput("t2_evicted_misses", seenMem.size(), m0 + 1);

    // 3: dirty eviction in set 12
    applyStimulus(1'b0, 32'hABCD_E832, 32'h0, 4'h0, lat);
    applyStimulus(1'b1, 32'hABCD_E832, 32'hBEEFDEAD, 4'hF, lat);
    checkOutput("t3_write_hit_latency", lat, 32'd2);
    checkOutput("t3_write_hit_rdata", lastResp, 32'hBEEFDEAD);
    applyStimulus(1'b0, 32'h0000_0832, 32'h0, 4'h0, lat);
    m0 = seenMem.size();
    applyStimulus(1'b0, 32'hAAAA_A832, 32'h0, 4'h0, lat);
    checkOutput("t3_wb_count", seenMem.size(), m0 + 2);
    checkOutput("t3_wb_we", {31'b0, seenMem[m0].we}, 32'd1);
    checkOutput("t3_wb_addr", {2'b00, seenMem[m0].addr}, 32'h2AF37A0C);
    checkOutput("t3_wb_wdata", seenMem[m0].wdata, 32'hBEEFDEAD);
    checkOutput("t3_refill_addr", {2'b00, seenMem[m0+1].addr}, 32'h2AAAAA0C);
    checkOutput("t3_refill_rdata", lastResp, 32'h70F0AA0C);
    applyStimulus(1'b0, 32'hABCD_E832, 32'h0, 4'h0, lat);
    checkOutput("t3_reread_rdata", lastResp, 32'hBEEFDEAD);

    // 4: strobed write miss
    ramMem[32'h3FF] = 32'h11111111;
    applyStimulus(1'b1, 32'h0000_0FFC, 32'h12345678, 4'b0011, lat);
    checkOutput("t4_refill_addr", {2'b00, seenMem[seenMem.size()-1].addr}, 32'h3FF);
    checkOutput("t4_merge_rdata", lastResp, 32'h11115678);
    applyStimulus(1'b0, 32'h0000_0FFC, 32'h0, 4'h0, lat);
    checkOutput("t4_hit_latency", lat, 32'd2);
    checkOutput("t4_hit_rdata", lastResp, 32'h11115678);

    // 6: reset during a refill
    memLatency = 1000;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0050;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_refill_req", {31'b0, mem_req}, 32'd1);
    checkOutput("t6_refill_addr", {2'b00, mem_addr}, 32'h14);
    reset = 1'b0;
    #1;
    checkOutput("t6_mem_req_drop", {31'b0, mem_req}, 32'd0);
    checkOutput("t6_ready_in_reset", {31'b0, req_ready}, 32'd0);
    modelReset();
    repeat (2) @(negedge clk);
    memLatency = 1;
    reset = 1'b1;
    #1 checkOutput("t6_ready_after", {31'b0, req_ready}, 32'd1);
    m0 = seenMem.size();
    applyStimulus(1'b0, 32'hABCD_E832, 32'h0, 4'h0, lat);
    checkOutput("t6_cached_misses", seenMem.size(), m0 + 1);
    checkOutput("t6_rdata", lastResp, 32'hBEEFDEAD);

    // 5: flush of two dirty lines
    applyStimulus(1'b1, 32'h0000_000C, 32'hCAFEF00D, 4'hF, lat);
    applyStimulus(1'b1, 32'h0000_001C, 32'h0BADBEEF, 4'b0101, lat);
    checkOutput("t5_strobe_rdata", lastResp, 32'h5AAD00EF);
    applyStimulus(1'b0, 32'h0000_0014, 32'h0, 4'h0, lat);
    m0 = seenMem.size();
    doFlush();
    checkOutput("t5_flush_count", seenMem.size(), m0 + 2);
    checkOutput("t5_flush0_addr", {2'b00, seenMem[m0].addr}, 32'h3);
    checkOutput("t5_flush0_wdata", seenMem[m0].wdata, 32'hCAFEF00D);
    checkOutput("t5_flush1_addr", {2'b00, seenMem[m0+1].addr}, 32'h7);
    checkOutput("t5_flush1_wdata", seenMem[m0+1].wdata, 32'h5AAD00EF);
    m0 = seenMem.size();
    applyStimulus(1'b0, 32'h0000_000C, 32'h0, 4'h0, lat);
    checkOutput("t5_rehit3_latency", lat, 32'd2);
    applyStimulus(1'b0, 32'h0000_001C, 32'h0, 4'h0, lat);
    checkOutput("t5_rehit7_latency", lat, 32'd2);
    checkOutput("t5_rehit_no_mem", seenMem.size(), m0);
    applyStimulus(1'b0, 32'h0000_080C, 32'h0, 4'h0, lat);
    m0 = seenMem.size();
    applyStimulus(1'b0, 32'h0000_100C, 32'h0, 4'h0, lat);
    checkOutput("t5_clean_evict_count", seenMem.size(), m0 + 1);
    checkOutput("t5_clean_evict_we", {31'b0, seenMem[m0].we}, 32'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
